datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Automatic driver of the datapath control interface, replacing manual switch entry. Accepts one
//  micro-op request (op, Rd, Rn, Rm, shift, imm8) over a valid/ready handshake.
//  Sequences the register-read, execute and writeback stages. Returns datapath_out and status as a
//  captured result with a one-cycle done pulse. Sits between a host (test FSM / future instruction
//  decoder) and the datapath.
// PARAMETERS
//  DATA_W  16  datapath word width; datapath_in = {(DATA_W-8)'b0, imm8}
// PORTS
//  clk           in   1       single clock; all state changes on rising edge
//  reset         in   1       asynchronous, active-high reset
//  req_valid     in   1       request present
//  req_ready     out  1       1 only in IDLE; accept = req_valid & req_ready at clk edge
//  req_op        in   3       000 MOV_IMM, 001 MOV_REG, 010 ADD, 011 CMP, 100 AND, 101 MVN, 11x illegal
//  req_rd        in   3       destination register
//  req_rn        in   3       A-operand register
//  req_rm        in   3       B-operand register
//  req_shift     in   2       shifter code applied to B
//  req_imm8      in   8       immediate for MOV_IMM
//  readnum       out  3       datapath register-read select
//  writenum      out  3       datapath writeback select
//  write, vsel   out  1 each  register-file write strobe; 1 = datapath_in, 0 = C
//  loada, loadb  out  1 each  A/B load strobes
//  asel, bsel    out  1 each  asel 1 = zero A input; bsel held 0
//  shift, ALUop  out  2 each  ALUop 00 ADD, 01 SUB, 10 AND, 11 MVN
//  loadc, loads  out  1 each  C and status load strobes
//  datapath_in   out  DATA_W  immediate to the writeback mux
//  datapath_out  in   DATA_W  C register value
//  status        in   1       datapath zero flag
//  result        out  DATA_W  datapath_out captured at writeback
//  result_status out  1       status captured at the end of EXEC
//  done          out  1       one-cycle pulse when the op completes
//  err           out  1       valid with done; 1 = illegal op
// BEHAVIOUR
//  - Reset (async): state IDLE; result 0; result_status 0; done 0; err 0; every strobe 0.
//    Reset mid-op aborts immediately with no further strobes; req_ready = 1 on the first edge after release.
//  - States: IDLE, LOAD_A, LOAD_B, EXEC, WB, DONE. Moore outputs decode from the state plus request
//    fields latched at accept. Fields change only at accept.
//  - Paths from accept: ALU ops ADD/AND: LOAD_A>LOAD_B>EXEC>WB>DONE.
//    MOV_REG, MVN: LOAD_B>EXEC>WB>DONE with asel=1. CMP: LOAD_A>LOAD_B>EXEC>DONE (SUB, no write).
//    MOV_IMM: WB>DONE with vsel=1. Illegal: DONE with err=1, no strobes.
//  - LOAD_A: readnum=Rn, loada=1. LOAD_B: readnum=Rm, loadb=1.
//  - EXEC: shift=req_shift, ALUop per op (MOV_REG uses ADD), loadc=1; loads=1 for ADD/CMP/AND/MVN only.
//  - WB: writenum=Rd, write=1. On the WB edge, result <= datapath_out; MOV_IMM stores the zero-extended imm8.
//    result_status <= status on the first edge after EXEC.
//  - DONE: done=1 for exactly one cycle, then IDLE. req_ready stays 0 in DONE.
//  - Latency (accept edge to done-high cycle): ALU 5, MOV_REG/MVN 4, CMP 4, MOV_IMM 2, illegal 1.
//  - Outside their states, all strobes are 0 and selects are 0. req_valid while busy is ignored.
//    Back-to-back ops: the next accept is possible in the cycle after DONE.
// CONFIGURATION
//  SEQ_STEP_EN defined: adds input port step (1 bit). Non-IDLE states advance only on cycles with step=1.
//    load/write strobes are ANDed with step, so each fires exactly once per stage.
//    IDLE accept is not gated. done is asserted in DONE and held until the stepped edge leaving it.
//  Not defined: no step port; one state per cycle.
// STRUCTURE
//  Shared package dp_seq_pkg: op-code, state and ALUop/shift constants, DATA_W default.
//  One sub-module, seq_decode: combinational op -> {use_a, use_b, do_write, do_loads, alu_op, asel, vsel, illegal}.
//  State register and result capture live in datapath_sequencer.
// TESTING
//  1 MOV_IMM Rd=3 imm8=8'h2A -> write=1 and writenum=3 and vsel=1 in cycle 1; done in cycle 2;
//    result=16'h002A.
//  2 With R1=5, R2=7 preloaded, ADD Rd=4 Rn=1 Rm=2 shift=00 -> loada/loadb/loadc each pulse once in order;
//    result=12; done at cycle 5.
//  3 CMP Rn=1 Rm=1 (both 9) -> result_status=1; write never asserted; done at cycle 4.
//  4 Illegal op 3'b111 -> done and err in cycle 1; no strobe ever high; req_ready=1 next cycle.
//  5 reset asserted during EXEC of ADD -> strobes 0 at once; Rd unchanged; result=0; next MOV_IMM completes normally.
//  6 SEQ_STEP_EN: MOV_REG with step low for 10 cycles -> state frozen, loadb fires once;
//    completes after 4 step pulses.

Source files
------------

// File: rtl/dp_seq_pkg.sv
// Shared op-code, state, ALU and shifter definitions for the datapath sequencer.
package dp_seq_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] OP_MOV_IMM = 3'b000;
  localparam logic [2:0] OP_MOV_REG = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_CMP     = 3'b011;
  localparam logic [2:0] OP_AND     = 3'b100;
  localparam logic [2:0] OP_MVN     = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WB,
    S_DONE
  } state_e;

  typedef struct packed {
    logic       use_a;
    logic       use_b;
    logic       do_write;
    logic       do_loads;
    logic [1:0] alu_op;
    logic       asel;
    logic       vsel;
    logic       illegal;
  } dec_t;

  // Entry state right after accept; later stages follow a fixed order.
  function automatic state_e first_state(input dec_t d);
    state_e s;
    if (d.illegal)
      s = S_DONE;
    else if (d.use_a)
      s = S_LOAD_A;
    else if (d.use_b)
      s = S_LOAD_B;
    else
      s = S_WB;
    return s;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational micro-op decode: which datapath stages an op needs and how to drive them.
module seq_decode
  import dp_seq_pkg::*;
(
  input  logic [2:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (op)
      OP_MOV_IMM: begin
        dec.do_write = 1'b1;
        dec.vsel     = 1'b1;
      end
      OP_MOV_REG: begin
        dec.use_b    = 1'b1;
        dec.do_write = 1'b1;
        dec.asel     = 1'b1;
        dec.alu_op   = ALU_ADD;
      end
      OP_ADD: begin
        dec.use_a    = 1'b1;
        dec.use_b    = 1'b1;
        dec.do_write = 1'b1;
        dec.do_loads = 1'b1;
        dec.alu_op   = ALU_ADD;
      end
      OP_CMP: begin
        dec.use_a    = 1'b1;
        dec.use_b    = 1'b1;
        dec.do_loads = 1'b1;
        dec.alu_op   = ALU_SUB;
      end
      OP_AND: begin
        dec.use_a    = 1'b1;
        dec.use_b    = 1'b1;
        dec.do_write = 1'b1;
        dec.do_loads = 1'b1;
        dec.alu_op   = ALU_AND;
      end
      OP_MVN: begin
        dec.use_b    = 1'b1;
        dec.do_write = 1'b1;
        dec.do_loads = 1'b1;
        dec.asel     = 1'b1;
        dec.alu_op   = ALU_MVN;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Drives the datapath control strobes for one accepted micro-op and captures its result.
// Build option SEQ_STEP_EN adds a step input: non-idle states then advance only on stepped cycles.
module datapath_sequencer
  import dp_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
`ifdef SEQ_STEP_EN
  input  logic              step,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [2:0]        req_rd,
  input  logic [2:0]        req_rn,
  input  logic [2:0]        req_rm,
  input  logic [1:0]        req_shift,
  input  logic [7:0]        req_imm8,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic              loadc,
  output logic              loads,
  output logic [DATA_W-1:0] datapath_in,
  input  logic [DATA_W-1:0] datapath_out,
  input  logic              status,
  output logic [DATA_W-1:0] result,
  output logic              result_status,
  output logic              done,
  output logic              err
);

  state_e state, nxt;
  dec_t   dec_in, dec_q, d;
  logic [2:0] rd_q, rn_q, rm_q, rd_c, rn_c, rm_c;
  logic [1:0] shift_q, shift_c;
  logic [7:0] imm_q;
  logic       acc, adv, gate;

  logic [2:0] readnum_r, writenum_r, n_readnum, n_writenum;
  logic [1:0] shift_r, aluop_r, n_shift, n_aluop;
  logic       write_r, vsel_r, loada_r, loadb_r, asel_r, loadc_r, loads_r, done_r, err_r;
  logic       n_write, n_vsel, n_loada, n_loadb, n_asel, n_loadc, n_loads, n_done, n_err;

  seq_decode u_dec (
    .op  (req_op),
    .dec (dec_in)
  );

`ifdef SEQ_STEP_EN
  assign gate = step;
`else
  assign gate = 1'b1;
`endif

  assign req_ready = (state == S_IDLE);
  assign acc       = (state == S_IDLE) && req_valid;
  assign adv       = (state == S_IDLE) || gate;

  // At the accept edge the outputs for the first stage come straight from the request.
  assign d       = acc ? dec_in    : dec_q;
  assign rd_c    = acc ? req_rd    : rd_q;
  assign rn_c    = acc ? req_rn    : rn_q;
  assign rm_c    = acc ? req_rm    : rm_q;
  assign shift_c = acc ? req_shift : shift_q;

  always_comb begin
    nxt = state;
    if (adv) begin
      case (state)
        S_IDLE:   if (acc) nxt = first_state(d);
        S_LOAD_A: nxt = S_LOAD_B;
        S_LOAD_B: nxt = S_EXEC;
        S_EXEC:   nxt = d.do_write ? S_WB : S_DONE;
        S_WB:     nxt = S_DONE;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    n_readnum  = '0;
    n_writenum = '0;
    n_shift    = '0;
    n_aluop    = '0;
    n_write    = 1'b0;
    n_vsel     = 1'b0;
    n_loada    = 1'b0;
    n_loadb    = 1'b0;
    n_asel     = 1'b0;
    n_loadc    = 1'b0;
    n_loads    = 1'b0;
    n_done     = 1'b0;
    n_err      = 1'b0;
    case (nxt)
      S_LOAD_A: begin
        n_readnum = rn_c;
        n_loada   = 1'b1;
      end
      S_LOAD_B: begin
        n_readnum = rm_c;
        n_loadb   = 1'b1;
      end
      S_EXEC: begin
        n_shift = shift_c;
        n_aluop = d.alu_op;
        n_asel  = d.asel;
        n_loadc = 1'b1;
        n_loads = d.do_loads;
      end
      S_WB: begin
        n_writenum = rd_c;
        n_write    = 1'b1;
        n_vsel     = d.vsel;
      end
      S_DONE: begin
        n_done = 1'b1;
        n_err  = d.illegal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      dec_q         <= '0;
      rd_q          <= '0;
      rn_q          <= '0;
      rm_q          <= '0;
      shift_q       <= '0;
      imm_q         <= '0;
      readnum_r     <= '0;
      writenum_r    <= '0;
      shift_r       <= '0;
      aluop_r       <= '0;
      write_r       <= 1'b0;
      vsel_r        <= 1'b0;
      loada_r       <= 1'b0;
      loadb_r       <= 1'b0;
      asel_r        <= 1'b0;
      loadc_r       <= 1'b0;
      loads_r       <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      result        <= '0;
      result_status <= 1'b0;
    end else begin
      state      <= nxt;
      readnum_r  <= n_readnum;
      writenum_r <= n_writenum;
      shift_r    <= n_shift;
      aluop_r    <= n_aluop;
      write_r    <= n_write;
      vsel_r     <= n_vsel;
      loada_r    <= n_loada;
      loadb_r    <= n_loadb;
      asel_r     <= n_asel;
      loadc_r    <= n_loadc;
      loads_r    <= n_loads;
      done_r     <= n_done;
      err_r      <= n_err;
      if (acc) begin
        dec_q   <= dec_in;
        rd_q    <= req_rd;
        rn_q    <= req_rn;
        rm_q    <= req_rm;
        shift_q <= req_shift;
        imm_q   <= req_imm8;
      end
      if (adv && state == S_WB)
        result <= d.vsel ? {{(DATA_W-8){1'b0}}, imm_q} : datapath_out;
      // Status lands in the datapath at the end of EXEC, so sample it one stage later.
      if (adv && d.use_b && (state == S_WB || (state == S_DONE && !d.do_write)))
        result_status <= status;
    end
  end

  assign datapath_in = {{(DATA_W-8){1'b0}}, imm_q};
  assign readnum     = readnum_r;
  assign writenum    = writenum_r;
  assign shift       = shift_r;
  assign ALUop       = aluop_r;
  assign vsel        = vsel_r;
  assign asel        = asel_r;
  assign bsel        = 1'b0;
  assign done        = done_r;
  assign err         = err_r;
  assign write       = write_r & gate;
  assign loada       = loada_r & gate;
  assign loadb       = loadb_r & gate;
  assign loadc       = loadc_r & gate;
  assign loads       = loads_r & gate;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench: a small datapath model answers the DUT's strobes, an op-level model predicts results.
module tb_datapath_sequencer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op, req_rd, req_rn, req_rm;
  logic [1:0]    req_shift;
  logic [7:0]    req_imm8;
  logic [2:0]    readnum, writenum;
  logic          write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [1:0]    shift, ALUop;
  logic [DW-1:0] datapath_in, datapath_out, result;
  logic          status, result_status, done, err;
`ifdef SEQ_STEP_EN
  logic          step;
`endif

  always #5 clk = ~clk;

  datapath_sequencer #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
`ifdef SEQ_STEP_EN
    .step(step),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
    .req_rn(req_rn), .req_rm(req_rm), .req_shift(req_shift), .req_imm8(req_imm8),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .loadc(loadc), .loads(loads), .datapath_in(datapath_in), .datapath_out(datapath_out),
    .status(status), .result(result), .result_status(result_status), .done(done), .err(err)
  );

  function automatic logic [DW-1:0] shf(input logic [DW-1:0] v, input logic [1:0] s);
    case (s)
      2'b00:   return v;
      2'b01:   return v << 1;
      2'b10:   return v >> 1;
      default: return {v[DW-1], v[DW-1:1]};
    endcase
  endfunction

  // Environment: register file, A/B/C registers and zero flag driven by the strobes.
  logic [DW-1:0] regs [8] = '{default: '0};
  logic [DW-1:0] a_r = '0, b_r = '0, c_r = '0;
  logic          z_r = 1'b0;
  logic [DW-1:0] ain, bin, alu_out;

  always_comb begin
    ain = asel ? '0 : a_r;
    bin = shf(b_r, shift);
    case (ALUop)
      2'b00:   alu_out = ain + bin;
      2'b01:   alu_out = ain - bin;
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write) regs[writenum] <= vsel ? datapath_in : c_r;
    if (loada) a_r <= regs[readnum];
    if (loadb) b_r <= regs[readnum];
    if (loadc) c_r <= alu_out;
    if (loads) z_r <= (alu_out == '0);
  end

  assign datapath_out = c_r;
  assign status       = z_r;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Op-level reference: architectural registers, flag and captured outputs.
  typedef struct {
    logic          err;
    int            lat;
    logic [7:0]    cnt;
    logic [DW-1:0] res;
    logic          rstat;
    int            acc_cyc;
  } exp_t;

  logic [DW-1:0] exp_regs [8] = '{default: '0};
  logic          exp_z     = 1'b0;
  logic [DW-1:0] exp_res   = '0;
  logic          exp_rstat = 1'b0;
  exp_t          expq [$];

  function automatic exp_t model(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                                 input logic [2:0] rm, input logic [1:0] sh, input logic [7:0] imm);
    exp_t e;
    logic [DW-1:0] av, bv, r;
    av = exp_regs[rn];
    bv = shf(exp_regs[rm], sh);
    r  = '0;
    e.err = 1'b0;
    e.acc_cyc = 0;
    case (op)
      3'd0: begin r = {8'h00, imm}; e.lat = 2; e.cnt = {2'd0, 2'd0, 2'd0, 2'd1}; end
      3'd1: begin r = bv;           e.lat = 4; e.cnt = {2'd0, 2'd1, 2'd1, 2'd1}; end
      3'd2: begin r = av + bv;      e.lat = 5; e.cnt = {2'd1, 2'd1, 2'd1, 2'd1}; end
      3'd3: begin r = av - bv;      e.lat = 4; e.cnt = {2'd1, 2'd1, 2'd1, 2'd0}; end
      3'd4: begin r = av & bv;      e.lat = 5; e.cnt = {2'd1, 2'd1, 2'd1, 2'd1}; end
      3'd5: begin r = ~bv;          e.lat = 4; e.cnt = {2'd0, 2'd1, 2'd1, 2'd1}; end
      default: begin e.err = 1'b1;  e.lat = 1; e.cnt = 8'd0; end
    endcase
    if (op inside {3'd2, 3'd3, 3'd4, 3'd5}) exp_z = (r == '0);
    if (op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}) exp_rstat = exp_z;
    if (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
      exp_regs[rd] = r;
      exp_res = r;
    end
    e.res   = exp_res;
    e.rstat = exp_rstat;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse, checks captured outputs once done drops.
  bit         pend = 0;
  exp_t       pexp;
  logic [1:0] ca, cb, cc, cw;
  logic       dprev;

  function automatic logic [1:0] sat(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  initial begin
    exp_t e;
    ca = 0; cb = 0; cc = 0; cw = 0; dprev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ca = 0; cb = 0; cc = 0; cw = 0; dprev = 0; pend = 0;
      end else begin
        if (loada) ca = sat(ca);
        if (loadb) cb = sat(cb);
        if (loadc) cc = sat(cc);
        if (write) cw = sat(cw);
        if (pend && !done) begin
          chk("result", 32'(result), 32'(pexp.res));
          chk("result_status", 32'(result_status), 32'(pexp.rstat));
          pend = 0;
        end
        if (done && !dprev) begin
          if (expq.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = expq.pop_front();
            chk("err", 32'(err), 32'(e.err));
`ifndef SEQ_STEP_EN
            chk("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
`endif
            chk("strobe_counts", 32'({ca, cb, cc, cw}), 32'(e.cnt));
            pexp = e;
            pend = 1;
          end
          ca = 0; cb = 0; cc = 0; cw = 0;
        end
        dprev = done;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [1:0] sh, input logic [7:0] imm,
                       input bit apply);
    exp_t e;
    int n;
    @(negedge clk);
    req_op = op; req_rd = rd; req_rn = rn; req_rm = rm; req_shift = sh; req_imm8 = imm;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_rd = 3'($urandom); req_rn = 3'($urandom);
    req_rm = 3'($urandom); req_shift = 2'($urandom); req_imm8 = 8'($urandom);
    if (apply) begin
      e = model(op, rd, rn, rm, sh, imm);
      e.acc_cyc = cyc;
      expq.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((expq.size() != 0 || pend || !req_ready) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [17:0] strobes();
    return {loada, loadb, loadc, loads, write, vsel, asel, bsel, readnum, writenum, shift, ALUop};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    logic [2:0] op;
    reset = 1'b1; req_valid = 1'b0;
    req_op = '0; req_rd = '0; req_rn = '0; req_rm = '0; req_shift = '0; req_imm8 = '0;
`ifdef SEQ_STEP_EN
    step = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_status", 32'(result_status), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // 1: MOV_IMM R3 = 0x2A, writeback in cycle 1
    issue(3'b000, 3'd3, 3'd0, 3'd0, 2'b00, 8'h2A, 1);
    chk("t1_wb_strobes", 32'({write, vsel, writenum}), 32'({1'b1, 1'b1, 3'd3}));
    wait_idle();
    chk("t1_result", 32'(result), 32'h2A);

    // 2: ADD R4 = R1 + R2 with R1=5, R2=7
    issue(3'b000, 3'd1, 3'd0, 3'd0, 2'b00, 8'd5, 1);
    issue(3'b000, 3'd2, 3'd0, 3'd0, 2'b00, 8'd7, 1);
    issue(3'b010, 3'd4, 3'd1, 3'd2, 2'b00, 8'd0, 1);
    wait_idle();
    chk("t2_result", 32'(result), 32'd12);

    // 3: CMP R1, R1 with both 9
    issue(3'b000, 3'd1, 3'd0, 3'd0, 2'b00, 8'd9, 1);
    issue(3'b011, 3'd6, 3'd1, 3'd1, 2'b00, 8'd0, 1);
    wait_idle();
    chk("t3_result_status", 32'(result_status), 32'd1);

    // 4: illegal op finishes in one cycle without strobes
    issue(3'b111, 3'd2, 3'd2, 3'd2, 2'b11, 8'hFF, 1);
    chk("t4_done_err", 32'({done, err}), 32'b11);
    chk("t4_strobes", 32'(strobes()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_ready_next", 32'(req_ready), 32'd1);
    wait_idle();

    // 5: reset during EXEC of an ADD aborts it
    issue(3'b010, 3'd5, 3'd1, 3'd2, 2'b00, 8'd0, 0);
    n = 0;
    while (!loadc && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_exec", 32'(loadc), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_strobes", 32'(strobes()), 32'd0);
    chk("t5_result", 32'(result), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    exp_res = '0;
    exp_rstat = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_ready", 32'(req_ready), 32'd1);
    chk("t5_rd_unchanged", 32'(regs[5]), 32'(exp_regs[5]));
    issue(3'b000, 3'd7, 3'd0, 3'd0, 2'b00, 8'h81, 1);
    wait_idle();
    chk("t5_after_reset", 32'(result), 32'h81);

`ifdef SEQ_STEP_EN
    // 6: MOV_REG single-stepped
    step = 1'b0;
    issue(3'b001, 3'd6, 3'd0, 3'd1, 2'b00, 8'd0, 1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (loadb) n++;
    end
    chk("t6_frozen_loadb", 32'(n), 32'd0);
    chk("t6_frozen_done", 32'(done), 32'd0);
    repeat (4) begin
      @(negedge clk);
      step = 1'b1;
      if (loadb) n++;
      #1;
      if (loadb) n++;
      @(negedge clk);
      step = 1'b0;
    end
    chk("t6_loadb_once", 32'(n), 32'd1);
    step = 1'b1;
    wait_idle();
    chk("t6_result", 32'(result), 32'd9);
`endif

    // Random ops, idle gaps of 0..2 cycles
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 15);
      op = (k >= 14) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      issue(op, 3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom), 8'($urandom), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    for (int r = 0; r < 8; r++) chk($sformatf("regfile_r%0d", r), 32'(regs[r]), 32'(exp_regs[r]));
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
